// File: rtl/linear_layer_backward.sv
// linear_layer_backward
//   Backward pass of the scalar linear layer y = WEIGHT*x + BIAS.
//   For each accepted (x, dL/dy) pair it streams dL/dx = WEIGHT*dL/dy with a
//   one-cycle latency. Over a batch of BATCH pairs it also accumulates
//   dL/dW = sum(x*dL/dy) and dL/dB = sum(dL/dy).
//
// Ports
//   clk           : clock, rising edge
//   reset_n       : synchronous active-low reset
//   init          : start/restart a batch, clears accumulators
//   ready         : idle or finished, a new init may be issued
//   valid_in      : x_block/grad_block carry a sample this cycle
//   x_block       : forward activation x (signed)
//   grad_block    : upstream gradient dL/dy (signed)
//   grad_in_valid : grad_in_block is valid this cycle
//   grad_in_block : dL/dx = WEIGHT*dL/dy (signed, wraps)
//   grad_w        : accumulated weight gradient (signed)
//   grad_b        : accumulated bias gradient (signed)
//   done          : one-cycle pulse, grad_w/grad_b final for the batch
module linear_layer_backward #(
  parameter int WIDTH  = 32,
  parameter int WEIGHT = 2,
  parameter int BATCH  = 4,
  localparam int ACC_WIDTH = 2*WIDTH + $clog2(BATCH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 init,
  output logic                 ready,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     x_block,
  input  logic [WIDTH-1:0]     grad_block,
  output logic                 grad_in_valid,
  output logic [WIDTH-1:0]     grad_in_block,
  output logic [ACC_WIDTH-1:0] grad_w,
  output logic [ACC_WIDTH-1:0] grad_b,
  output logic                 done
);

  localparam int CNT_W = (BATCH > 1) ? $clog2(BATCH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BATCH - 1);
  localparam logic signed [WIDTH-1:0] WEIGHT_S = WIDTH'(WEIGHT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                       state_r;
  logic [CNT_W-1:0]             cnt_r;
  logic signed [2*WIDTH-1:0]    prod_r;
  logic signed [WIDTH-1:0]      gpend_r;   // dL/dy waiting to enter grad_b
  logic                         pend_r;    // prod_r/gpend_r hold an unaccumulated sample
  logic signed [ACC_WIDTH-1:0]  acc_w_r;
  logic signed [ACC_WIDTH-1:0]  acc_b_r;
  logic                         ready_r;
  logic                         done_r;
  logic                         giv_r;
  logic [WIDTH-1:0]             gib_r;

  logic signed [WIDTH-1:0]      x_s;
  logic signed [WIDTH-1:0]      g_s;
  logic signed [2*WIDTH-1:0]    prod_s;
  logic signed [WIDTH-1:0]      dx_s;
  logic signed [ACC_WIDTH-1:0]  prod_ext_s;
  logic signed [ACC_WIDTH-1:0]  g_ext_s;

  assign x_s    = x_block;
  assign g_s    = grad_block;
  // Operands are widened first so the full signed product is kept.
  assign prod_s = (2*WIDTH)'(x_s) * (2*WIDTH)'(g_s);
  // Low WIDTH bits only: wraps exactly like the forward path.
  assign dx_s   = g_s * WEIGHT_S;

  assign prod_ext_s = {{(ACC_WIDTH-2*WIDTH){prod_r[2*WIDTH-1]}}, prod_r};
  assign g_ext_s    = {{(ACC_WIDTH-WIDTH){gpend_r[WIDTH-1]}}, gpend_r};

  // Batch FSM, sample capture, accumulation and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      prod_r  <= '0;
      gpend_r <= '0;
      pend_r  <= 1'b0;
      acc_w_r <= '0;
      acc_b_r <= '0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      giv_r   <= 1'b0;
      gib_r   <= '0;
    end else begin
      giv_r  <= 1'b0;
      done_r <= 1'b0;
      if (init) begin
        // Restart wins over any sample presented in the same cycle.
        state_r <= ACCUM;
        ready_r <= 1'b0;
        cnt_r   <= '0;
        prod_r  <= '0;
        gpend_r <= '0;
        pend_r  <= 1'b0;
        acc_w_r <= '0;
        acc_b_r <= '0;
      end else begin
        // Previous cycle's sample lands in the accumulators one edge later.
        if (pend_r) begin
          acc_w_r <= acc_w_r + prod_ext_s;
          acc_b_r <= acc_b_r + g_ext_s;
        end else begin
          acc_w_r <= acc_w_r;
          acc_b_r <= acc_b_r;
        end
        pend_r <= 1'b0;
        case (state_r)
          IDLE: begin
            ready_r <= 1'b1;
          end
          ACCUM: begin
            ready_r <= 1'b0;
            if (valid_in) begin
              gib_r   <= dx_s;
              giv_r   <= 1'b1;
              prod_r  <= prod_s;
              gpend_r <= g_s;
              pend_r  <= 1'b1;
              if (cnt_r == LAST_IDX) begin
                cnt_r   <= '0;
                state_r <= DRAIN;
              end else begin
                cnt_r   <= cnt_r + CNT_W'(1);
              end
            end else begin
              cnt_r <= cnt_r;
            end
          end
          DRAIN: begin
            state_r <= DONE;
            ready_r <= 1'b1;
            done_r  <= 1'b1;
          end
          DONE: begin
            ready_r <= 1'b1;
          end
          default: begin
            state_r <= IDLE;
            ready_r <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ready         = ready_r;
  assign done          = done_r;
  assign grad_in_valid = giv_r;
  assign grad_in_block = gib_r;
  assign grad_w        = acc_w_r;
  assign grad_b        = acc_b_r;

endmodule

// File: tb/tb_linear_layer_backward.sv
module tb_linear_layer_backward;

  logic        clk;
  logic        reset_n;
  logic        init;
  logic        ready;
  logic        valid_in;
  logic [31:0] x_block;
  logic [31:0] grad_block;
  logic        grad_in_valid;
  logic [31:0] grad_in_block;
  logic [66:0] grad_w;
  logic [66:0] grad_b;
  logic        done;

  int checks;
  int failures;

  linear_layer_backward dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .init          (init),
    .ready         (ready),
    .valid_in      (valid_in),
    .x_block       (x_block),
    .grad_block    (grad_block),
    .grad_in_valid (grad_in_valid),
    .grad_in_block (grad_in_block),
    .grad_w        (grad_w),
    .grad_b        (grad_b),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [31:0] x, input logic [31:0] g);
    valid_in   = 1'b1;
    x_block    = x;
    grad_block = g;
    tick();
    valid_in   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [66:0] hold_w;
  logic [66:0] hold_b;

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0; init = 1'b0; valid_in = 1'b0;
    x_block = 32'd0; grad_block = 32'd0;
    tick(); tick();
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_giv", grad_in_valid, 0);
    chk("rst_gw", grad_w, 0);
    chk("rst_gb", grad_b, 0);
    chk("rst_gib", grad_in_block, 0);
    reset_n = 1'b1;

    // IDLE ignores valid_in
    sample(32'd3, 32'd3);
    chk("idle_giv", grad_in_valid, 0);
    chk("idle_ready", ready, 1);

    // Basic batch
    init = 1'b1; tick(); init = 1'b0;
    chk("b_ready0", ready, 0);
    sample(32'd1, 32'd10);
    chk("b_giv0", grad_in_valid, 1);
    chk("b_gib0", grad_in_block, 32'd20);
    sample(32'd2, 32'hFFFF_FFFF);
    chk("b_gib1", grad_in_block, 32'hFFFF_FFFE);
    sample(32'd3, 32'd5);
    chk("b_gib2", grad_in_block, 32'd10);
    sample(32'd4, 32'd0);
    chk("b_gib3", grad_in_block, 32'd0);
    chk("b_giv3", grad_in_valid, 1);
    chk("b_done_early", done, 0);
    tick();
    chk("b_giv_off", grad_in_valid, 0);
    chk("b_done", done, 1);
    chk("b_gw", grad_w, 67'd23);
    chk("b_gb", grad_b, 67'd14);
    chk("b_ready", ready, 1);
    // DONE ignores valid_in
    sample(32'd7, 32'd7);
    chk("done_giv", grad_in_valid, 0);
    chk("done_pulse", done, 0);
    chk("done_gw_hold", grad_w, 67'd23);

    // Gapped batch
    init = 1'b1; tick(); init = 1'b0;
    chk("g_clear", grad_w, 0);
    sample(32'd1, 32'd10); idle(3);
    chk("g_giv_gap", grad_in_valid, 0);
    sample(32'd2, 32'hFFFF_FFFF); idle(3);
    sample(32'd3, 32'd5); idle(3);
    chk("g_nodone", done, 0);
    chk("g_ready_mid", ready, 0);
    sample(32'd4, 32'd0);
    tick();
    chk("g_done", done, 1);
    chk("g_gw", grad_w, 67'd23);
    chk("g_gb", grad_b, 67'd14);

    // Extremes
    init = 1'b1; tick(); init = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample(32'h8000_0000, 32'h8000_0000);
      chk("e_gib", grad_in_block, 32'd0);
    end
    tick();
    chk("e_done", done, 1);
    chk("e_gw", grad_w, 67'h1_0000_0000_0000_0000);
    chk("e_gb", grad_b, 67'h7_FFFF_FFFE_0000_0000);
    init = 1'b1; tick(); init = 1'b0;
    sample(32'd1, 32'h4000_0000);
    chk("e_wrap", grad_in_block, 32'h8000_0000);

    // Restart with init + valid_in together
    init = 1'b1; tick(); init = 1'b0;
    sample(32'd5, 32'd5);
    sample(32'd1, 32'd1);
    init = 1'b1; valid_in = 1'b1; x_block = 32'd9; grad_block = 32'd9;
    tick();
    init = 1'b0; valid_in = 1'b0;
    chk("r_drop_giv", grad_in_valid, 0);
    chk("r_clear_w", grad_w, 0);
    chk("r_clear_b", grad_b, 0);
    for (int i = 0; i < 4; i++) begin
      sample(32'd1, 32'd1);
      chk("r_nodone", done, 0);
    end
    tick();
    chk("r_done", done, 1);
    chk("r_gw", grad_w, 67'd4);
    chk("r_gb", grad_b, 67'd4);
    tick();
    chk("r_single", done, 0);

    // Reset mid-batch
    init = 1'b1; tick(); init = 1'b0;
    sample(32'd1, 32'd10);
    sample(32'd2, 32'd20);
    sample(32'd3, 32'd30);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("m_gw", grad_w, 0);
    chk("m_gb", grad_b, 0);
    chk("m_gib", grad_in_block, 0);
    chk("m_giv", grad_in_valid, 0);
    chk("m_ready", ready, 1);
    chk("m_done", done, 0);
    sample(32'd3, 32'd3);
    chk("m_idle_giv", grad_in_valid, 0);
    init = 1'b1; tick(); init = 1'b0;
    sample(32'd1, 32'd10);
    sample(32'd2, 32'hFFFF_FFFF);
    sample(32'd3, 32'd5);
    sample(32'd4, 32'd0);
    tick();
    chk("m2_done", done, 1);
    chk("m2_gw", grad_w, 67'd23);
    chk("m2_gb", grad_b, 67'd14);

    // Result hold and clear
    hold_w = 67'd23;
    hold_b = 67'd14;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("h_gw", grad_w, hold_w);
      chk("h_gb", grad_b, hold_b);
      chk("h_done", done, 0);
      chk("h_ready", ready, 1);
    end
    init = 1'b1; tick(); init = 1'b0;
    chk("h_clr_w", grad_w, 0);
    chk("h_clr_b", grad_b, 0);
    chk("h_ready0", ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
